trace_capture: RTL and testbench
================================

Name: trace_capture

Overview:
- Synthesizable multi-channel pipeline trace buffer. It is the on-chip successor to cycle-by-cycle $display tracing of core stages.
- Each cycle it samples CH channels of W-bit pipeline state (e.g. IF/ID/EX valids, branch, stall, writeback data), stamped with a free-running cycle count, into a circular buffer of DEPTH entries.
- Capture stops a programmable number of samples after a masked trigger event.
- The frozen trace is read back by logical index, oldest entry first.

Parameters:
- CH, 4: number of sampled channels.
- W, 16: bits per channel.
- DEPTH, 64: buffer entries; must be a power of two, at least 2.
- AW, 6: log2(DEPTH).
- CYC_W, 16: cycle-stamp width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- sample_i  in  CH*W  channel data; channel k is bits [k*W +: W]
- sample_en_i  in  1  write the current sample this cycle
- trig_i  in  CH  per-channel event flags
- trig_mask_i  in  CH  trigger enable per channel; latched at arm
- post_len_i  in  AW+1  samples to record after the trigger sample; latched at arm; 0..DEPTH-1 legal
- arm_i  in  1  start capture (pulse)
- abort_i  in  1  stop capture, keep data
- rd_idx_i  in  AW  logical read index, 0 = oldest
- rd_data_o  out  CH*W  read data
- rd_cycle_o  out  CYC_W  cycle stamp of read entry
- rd_valid_o  out  1  rd_idx_i < count_o at request time
- state_o  out  2  0=IDLE, 1=RUN, 2=POST, 3=DONE
- count_o  out  AW+1  valid entries, saturates at DEPTH
- trig_idx_o  out  AW  logical index of the trigger sample
- triggered_o  out  1  trigger seen in current capture

Behaviour:
- Reset (rst=0 at a clk edge):
  - state IDLE; wr_ptr, count_o, trig_idx_o, cycle counter, rd_data_o and rd_cycle_o all 0.
  - rd_valid_o and triggered_o 0.
  - Latched mask and post_len cleared.
  - Buffer RAM contents are don't-care.
  - Reset mid-capture discards everything.
- Cycle counter: increments by 1 every clk while rst=1; wraps modulo 2^CYC_W. The stamp stored is the counter value in the write cycle.
- IDLE / DONE:
  - No writes.
  - arm_i=1: latch trig_mask_i and post_len_i; clear wr_ptr, count_o and triggered_o; go to RUN the next cycle.
- RUN:
  - If sample_en_i=1: write {sample_i, stamp} at wr_ptr; wr_ptr increments modulo DEPTH; count_o increments, saturating at DEPTH.
  - Trigger condition = |(trig_i & mask) with sample_en_i=1. The trigger sample is itself written.
  - On trigger: set triggered_o. trig_idx_o = logical index of that entry, i.e. (count_o if not yet full, else DEPTH-1), adjusted later as described under POST.
  - On trigger: load post counter with post_len. If post_len=0 go to DONE, otherwise go to POST.
  - Triggers are ignored in the arm cycle itself; evaluation begins in the first RUN cycle.
- POST:
  - Each write decrements the post counter; cycles with no write hold it.
  - When the write that brings the counter to 0 completes, go to DONE.
  - Each write made while count_o is already DEPTH means the oldest entry was overwritten; decrement trig_idx_o by 1 for each such write.
  - post_len ≤ DEPTH-1 guarantees the trigger entry survives.
- abort_i=1 in RUN or POST: go to DONE next cycle; the write in that cycle still occurs. abort_i in IDLE/DONE has no effect.
- arm_i in RUN or POST is ignored.
- arm_i and abort_i together: abort wins in RUN/POST, arm wins in IDLE/DONE.
- Readout:
  - Physical address = (count_o==DEPTH ? wr_ptr : 0) + rd_idx_i, modulo DEPTH.
  - rd_data_o and rd_cycle_o are registered, 1-cycle latency, valid in any state.
  - If rd_idx_i ≥ count_o: data outputs 0 and rd_valid_o=0.
  - Reading the entry being written in the same cycle returns the old contents.

Test Plan (DEPTH=8, CH=4, W=8, CYC_W=16):
- Basic capture: reset; arm with mask=4'b0001, post_len=2; sample_en=1 with sample=cycle-derived ramp; pulse trig_i[0] on the 3rd RUN sample -> DONE after 5 writes; count_o=5; trig_idx_o=2; read idx 0..4 returns ramp values in order with consecutive stamps.
- Wrap: arm with post_len=3; trigger on the 12th sample -> 15 writes; count_o=8; reads return samples 8..15; trig_idx_o=4.
- Masking: mask=4'b0100; pulse trig_i[0] and trig_i[1] -> stays RUN. Pulse trig_i[2] -> trigger. With post_len=0 -> DONE the next cycle with trig_idx_o = count_o-1.
- Gaps: sample_en toggles 1,0,1,0 in POST with post_len=2 -> exactly 2 writes after trigger; stamps are non-consecutive, differing by 2.
- Abort and re-arm: abort in RUN after 3 samples -> DONE, count_o=3, triggered_o=0. Re-arm -> count_o=0, rd_idx 0 gives rd_valid_o=0 and zero data.
- Reset mid-POST: deassert rst for 1 cycle -> state_o=0, count_o=0, rd_cycle_o=0; the following arm starts clean.

Source files
------------

// File: rtl/trace_capture.sv
// trace_capture: multi-channel pipeline trace buffer.
// Each enabled cycle stores the channel samples with a free-running cycle
// stamp in a circular RAM. A masked trigger starts a post-trigger countdown,
// after which capture freezes. The frozen trace is read back by logical
// index, oldest entry first, with one cycle of read latency.
module trace_capture #(
  parameter int CH    = 4,
  parameter int W     = 16,
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int CYC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH*W-1:0]   sample_i,
  input  logic              sample_en_i,
  input  logic [CH-1:0]     trig_i,
  input  logic [CH-1:0]     trig_mask_i,
  input  logic [AW:0]       post_len_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [AW-1:0]     rd_idx_i,
  output logic [CH*W-1:0]   rd_data_o,
  output logic [CYC_W-1:0]  rd_cycle_o,
  output logic              rd_valid_o,
  output logic [1:0]        state_o,
  output logic [AW:0]       count_o,
  output logic [AW-1:0]     trig_idx_o,
  output logic              triggered_o
);

  localparam int DW = CH*W + CYC_W;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_POST = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Entry count saturates once the ring has wrapped.
  function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
    if (v == FULL) return v;
    return v + 1'b1;
  endfunction

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    trig_idx_q, trig_idx_d;
  logic             triggered_q, triggered_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CH-1:0]    mask_q, mask_d;
  logic [AW:0]      post_len_q, post_len_d;
  logic [AW:0]      post_cnt_q, post_cnt_d;
  logic [CH*W-1:0]  rd_data_q, rd_data_d;
  logic [CYC_W-1:0] rd_cycle_q, rd_cycle_d;
  logic             rd_valid_q, rd_valid_d;

  logic [DW-1:0]    mem [DEPTH];

  logic             full;
  logic             wr_en;
  logic             trig_hit;
  logic [AW-1:0]    rd_addr;

  // Capture control: next-state, pointers, trigger bookkeeping and readout.
  always_comb begin
    full     = (count_q == FULL);
    wr_en    = sample_en_i && ((state_q == S_RUN) || (state_q == S_POST));
    trig_hit = wr_en && (state_q == S_RUN) && (|(trig_i & mask_q));

    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    trig_idx_d  = trig_idx_q;
    triggered_d = triggered_q;
    mask_d      = mask_q;
    post_len_d  = post_len_q;
    post_cnt_d  = post_cnt_q;
    cyc_d       = cyc_q + 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm_i) begin
          mask_d      = trig_mask_i;
          post_len_d  = post_len_i;
          wr_ptr_d    = '0;
          count_d     = '0;
          triggered_d = 1'b0;
          state_d     = S_RUN;
        end
      end
      default: begin
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = sat_inc(count_q);
        end
        if (trig_hit) begin
          // Logical index of the entry being written right now.
          triggered_d = 1'b1;
          trig_idx_d  = full ? AW'(DEPTH-1) : count_q[AW-1:0];
          post_cnt_d  = post_len_q;
          state_d     = (post_len_q == '0) ? S_DONE : S_POST;
        end else if ((state_q == S_POST) && wr_en) begin
          post_cnt_d = post_cnt_q - 1'b1;
          // Overwriting the oldest entry shifts the trigger one slot older.
          if (full) trig_idx_d = trig_idx_q - 1'b1;
          if (post_cnt_q == (AW+1)'(1)) state_d = S_DONE;
        end
        if (abort_i) state_d = S_DONE;
      end
    endcase

    rd_addr    = (full ? wr_ptr_q : '0) + rd_idx_i;
    rd_valid_d = ({1'b0, rd_idx_i} < count_q);
    rd_data_d  = '0;
    rd_cycle_d = '0;
    if (rd_valid_d) {rd_data_d, rd_cycle_d} = mem[rd_addr];
  end

  // Register all control state and the read port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      trig_idx_q  <= '0;
      triggered_q <= 1'b0;
      cyc_q       <= '0;
      mask_q      <= '0;
      post_len_q  <= '0;
      post_cnt_q  <= '0;
      rd_data_q   <= '0;
      rd_cycle_q  <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      trig_idx_q  <= trig_idx_d;
      triggered_q <= triggered_d;
      cyc_q       <= cyc_d;
      mask_q      <= mask_d;
      post_len_q  <= post_len_d;
      post_cnt_q  <= post_cnt_d;
      rd_data_q   <= rd_data_d;
      rd_cycle_q  <= rd_cycle_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Trace RAM write; contents are not reset.
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[wr_ptr_q] <= {sample_i, cyc_q};
  end

  assign rd_data_o   = rd_data_q;
  assign rd_cycle_o  = rd_cycle_q;
  assign rd_valid_o  = rd_valid_q;
  assign state_o     = state_q;
  assign count_o     = count_q;
  assign trig_idx_o  = trig_idx_q;
  assign triggered_o = triggered_q;

endmodule

// File: tb/tb_trace_capture.sv
// Testbench for trace_capture (DEPTH=8, CH=4, W=8, CYC_W=16).
// A queue-based model of the retained trace is compared against the DUT on
// every cycle; directed scenarios add literal expectations.
module tb_trace_capture;

  localparam int CH = 4, W = 8, DEPTH = 8, AW = 3, CYC_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH*W-1:0]   sample;
  logic              sample_en;
  logic [CH-1:0]     trig;
  logic [CH-1:0]     trig_mask;
  logic [AW:0]       post_len;
  logic              arm;
  logic              abort;
  logic [AW-1:0]     rd_idx;
  logic [CH*W-1:0]   rd_data;
  logic [CYC_W-1:0]  rd_cycle;
  logic              rd_valid;
  logic [1:0]        state;
  logic [AW:0]       count;
  logic [AW-1:0]     trig_idx;
  logic              triggered;

  trace_capture #(.CH(CH), .W(W), .DEPTH(DEPTH), .AW(AW), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .sample_i(sample), .sample_en_i(sample_en),
    .trig_i(trig), .trig_mask_i(trig_mask), .post_len_i(post_len),
    .arm_i(arm), .abort_i(abort), .rd_idx_i(rd_idx),
    .rd_data_o(rd_data), .rd_cycle_o(rd_cycle), .rd_valid_o(rd_valid),
    .state_o(state), .count_o(count), .trig_idx_o(trig_idx),
    .triggered_o(triggered)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist holds the retained entries oldest-first as {data, stamp}.
  logic [47:0] hist[$];
  int          m_state = 0;
  int          m_total = 0;
  int          m_tpos  = 0;
  int          m_left  = 0;
  int          nxt;
  bit          m_trig  = 1'b0;
  logic [3:0]  m_mask  = '0;
  int          m_plen  = 0;
  logic [15:0] m_cyc   = '0;
  logic [31:0] m_rd_data  = '0;
  logic [15:0] m_rd_cyc   = '0;
  bit          m_rd_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      hist.delete();
      m_state = 0; m_total = 0; m_tpos = 0; m_left = 0; m_trig = 0;
      m_mask = '0; m_plen = 0; m_cyc = '0;
      m_rd_data = '0; m_rd_cyc = '0; m_rd_valid = 0;
    end else begin
      if (int'(rd_idx) < hist.size()) begin
        m_rd_valid = 1;
        m_rd_data  = hist[rd_idx][47:16];
        m_rd_cyc   = hist[rd_idx][15:0];
      end else begin
        m_rd_valid = 0; m_rd_data = '0; m_rd_cyc = '0;
      end
      nxt = m_state;
      if (m_state == 0 || m_state == 3) begin
        if (arm) begin
          m_mask = trig_mask; m_plen = int'(post_len);
          hist.delete(); m_total = 0; m_trig = 0; nxt = 1;
        end
      end else begin
        if (sample_en) begin
          hist.push_back({sample, m_cyc});
          if (hist.size() > DEPTH) void'(hist.pop_front());
          m_total++;
          if (m_state == 1 && (trig & m_mask) != 0) begin
            m_trig = 1; m_tpos = m_total - 1; m_left = m_plen;
            nxt = (m_plen == 0) ? 3 : 2;
          end else if (m_state == 2) begin
            m_left--;
            if (m_left == 0) nxt = 3;
          end
        end
        if (abort) nxt = 3;
      end
      m_state = nxt;
      m_cyc++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", state, m_state);
      chk("count", count, hist.size());
      chk("triggered", triggered, m_trig);
      chk("rd_valid", rd_valid, m_rd_valid);
      chk("rd_data", rd_data, m_rd_data);
      chk("rd_cycle", rd_cycle, m_rd_cyc);
      if (m_trig) chk("trig_idx", trig_idx, m_tpos - (m_total - hist.size()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [3:0] m, input logic [3:0] pl);
    arm = 1; trig_mask = m; post_len = pl; sample_en = 0; trig = 0;
    step();
    arm = 0;
  endtask

  logic [31:0] vals [16];
  logic [15:0] stamps [8];

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; sample = '0; sample_en = 0; trig = '0; trig_mask = '0;
    post_len = '0; arm = 0; abort = 0; rd_idx = '0;
    step();
    chk_en = 1;
    step();
    chk("reset_state", state, 0);
    chk("reset_count", count, 0);
    chk("reset_rd_cycle", rd_cycle, 0);
    chk("reset_triggered", triggered, 0);
    rst = 1;
    step();

    // Basic capture
    do_arm(4'b0001, 4'd2);
    chk("basic_run", state, 1);
    for (int i = 0; i < 5; i++) begin
      vals[i] = {8'(i+8'h13), 8'(i+8'h12), 8'(i+8'h11), 8'(i+8'h10)};
      sample = vals[i]; sample_en = 1; trig = (i == 2) ? 4'b0001 : 4'b0000;
      step();
    end
    sample_en = 0; trig = 0;
    chk("basic_done", state, 3);
    chk("basic_count", count, 5);
    chk("basic_trig_idx", trig_idx, 2);
    chk("basic_triggered", triggered, 1);
    for (int i = 0; i < 5; i++) begin
      rd_idx = 3'(i);
      step();
      chk("basic_rd_data", rd_data, vals[i]);
      stamps[i] = rd_cycle;
      if (i > 0) chk("basic_stamp_step", 16'(stamps[i] - stamps[i-1]), 1);
    end

    // Wrap
    do_arm(4'b0001, 4'd3);
    for (int i = 0; i < 15; i++) begin
      vals[i] = $urandom;
      sample = vals[i]; sample_en = 1; trig = (i == 11) ? 4'b0001 : 4'b0000;
      step();
    end
    sample_en = 0; trig = 0;
    chk("wrap_done", state, 3);
    chk("wrap_count", count, 8);
    chk("wrap_trig_idx", trig_idx, 4);
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      step();
      chk("wrap_rd_data", rd_data, vals[7+i]);
    end

    // Masking
    do_arm(4'b0100, 4'd0);
    for (int i = 0; i < 3; i++) begin
      sample = $urandom; sample_en = 1; trig = 4'b0011;
      step();
    end
    chk("mask_still_run", state, 1);
    chk("mask_not_trig", triggered, 0);
    sample = $urandom; trig = 4'b0100;
    step();
    sample_en = 0; trig = 0;
    chk("mask_done", state, 3);
    chk("mask_count", count, 4);
    chk("mask_trig_idx", trig_idx, 3);

    // Gaps in POST
    do_arm(4'b0001, 4'd2);
    for (int i = 0; i < 3; i++) begin
      sample = $urandom; sample_en = 1; trig = (i == 2) ? 4'b0001 : 4'b0000;
      step();
    end
    trig = 0;
    for (int i = 0; i < 4; i++) begin
      sample = $urandom; sample_en = (i % 2 == 0);
      step();
    end
    sample_en = 0;
    chk("gap_done", state, 3);
    chk("gap_count", count, 5);
    rd_idx = 3'd3; step(); stamps[3] = rd_cycle;
    rd_idx = 3'd4; step(); stamps[4] = rd_cycle;
    chk("gap_stamp_diff", 16'(stamps[4] - stamps[3]), 2);

    // Abort and re-arm
    do_arm(4'b0001, 4'd2);
    for (int i = 0; i < 3; i++) begin
      sample = $urandom; sample_en = 1;
      step();
    end
    sample_en = 0; abort = 1;
    step();
    abort = 0;
    chk("abort_done", state, 3);
    chk("abort_count", count, 3);
    chk("abort_triggered", triggered, 0);
    do_arm(4'b0001, 4'd2);
    chk("rearm_count", count, 0);
    chk("rearm_state", state, 1);
    rd_idx = 3'd0;
    step();
    chk("rearm_rd_valid", rd_valid, 0);
    chk("rearm_rd_data", rd_data, 0);

    // Reset mid-POST
    do_arm(4'b0001, 4'd5);
    for (int i = 0; i < 3; i++) begin
      sample = $urandom; sample_en = 1; trig = (i == 1) ? 4'b0001 : 4'b0000;
      step();
    end
    sample_en = 0; trig = 0;
    chk("midpost_state", state, 2);
    rst = 0;
    step();
    rst = 1;
    chk("rst_state", state, 0);
    chk("rst_count", count, 0);
    chk("rst_rd_cycle", rd_cycle, 0);
    do_arm(4'b0001, 4'd1);
    for (int i = 0; i < 3; i++) begin
      sample = $urandom; sample_en = 1;
      step();
    end
    sample_en = 0;
    chk("clean_count", count, 3);
    chk("clean_triggered", triggered, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 399) != 0);
      arm       = ($urandom_range(0, 15) == 0);
      abort     = ($urandom_range(0, 39) == 0);
      sample_en = ($urandom_range(0, 3) != 0);
      sample    = $urandom;
      trig      = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      trig_mask = 4'($urandom);
      post_len  = 4'($urandom_range(0, DEPTH-1));
      rd_idx    = 3'($urandom);
      step();
    end
    rst = 1; arm = 0; abort = 0; sample_en = 0; trig = 0;
    step();
    chk_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
